// File: rtl/sha256_pkg.sv
// ============================================================================
// Module  : sha256_pkg
// Brief   : Shared types and helpers for the sha256 host controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sha256_pkg;

    localparam int DIGEST_WORDS = 8;
    localparam int START_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_READ  = 3'd4,
        ST_RESP  = 3'd5
    } host_state_t;

    function automatic logic [31:0] rotl1(input logic [31:0] x);
        return {x[30:0], x[31]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/sha256_host.sv
// ============================================================================
// Module  : sha256_host
// Brief   : Command-driven host that writes a message, kicks the sha256 core
//           and returns the digest with a cycle count.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sha256_host
    import sha256_pkg::*;
#(
    parameter int NUM_OF_WORDS   = 20,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [31:0]  cmd_seed,
    input  logic [15:0]  cmd_msg_addr,
    input  logic [15:0]  cmd_out_addr,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [255:0] res_digest,
    output logic [31:0]  res_cycles,
    output logic         res_timeout,
    output logic         core_start,
    output logic [15:0]  core_message_addr,
    output logic [15:0]  core_output_addr,
    input  logic         core_done,
    output logic         mem_sel,
    output logic         mem_clk,
    output logic         mem_we,
    output logic [15:0]  mem_addr,
    output logic [31:0]  mem_write_data,
    input  logic [31:0]  mem_read_data
);

    localparam int IDX_W = 11;
    localparam logic [IDX_W-1:0] c_last_word   = IDX_W'(NUM_OF_WORDS - 1);
    localparam logic [IDX_W-1:0] c_zero_word   = IDX_W'(NUM_OF_WORDS - 2);
    localparam logic [IDX_W-1:0] c_start_last  = IDX_W'(START_CYCLES - 1);
    localparam logic [IDX_W-1:0] c_read_last   = IDX_W'(DIGEST_WORDS);
    localparam logic [IDX_W-1:0] c_addr_last   = IDX_W'(DIGEST_WORDS - 1);
    localparam logic [31:0]      c_wait_last   = 32'(TIMEOUT_CYCLES - 1);

    host_state_t      r_state;
    logic [IDX_W-1:0] r_idx;
    logic [31:0]      r_wait;
    logic [31:0]      r_digest [DIGEST_WORDS];

    assign mem_clk = clk;

    for (genvar g = 0; g < DIGEST_WORDS; g++) begin : g_pack
        assign res_digest[255-32*g -: 32] = r_digest[g];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state           <= ST_IDLE;
            r_idx             <= '0;
            r_wait            <= '0;
            cmd_ready         <= 1'b0;
            res_valid         <= 1'b0;
            res_cycles        <= '0;
            res_timeout       <= 1'b0;
            core_start        <= 1'b0;
            core_message_addr <= '0;
            core_output_addr  <= '0;
            mem_sel           <= 1'b0;
            mem_we            <= 1'b0;
            mem_addr          <= '0;
            mem_write_data    <= '0;
            for (int k = 0; k < DIGEST_WORDS; k++) begin
                r_digest[k] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_ready && cmd_valid) begin
                        cmd_ready         <= 1'b0;
                        core_message_addr <= cmd_msg_addr;
                        core_output_addr  <= cmd_out_addr;
                        mem_sel           <= 1'b1;
                        mem_we            <= 1'b1;
                        mem_addr          <= cmd_msg_addr;
                        mem_write_data    <= cmd_seed;
                        res_timeout       <= 1'b0;
                        r_idx             <= '0;
                        r_state           <= ST_WRITE;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end

                ST_WRITE: begin
                    if (r_idx == c_last_word) begin
                        mem_sel    <= 1'b0;
                        mem_we     <= 1'b0;
                        core_start <= 1'b1;
                        r_idx      <= '0;
                        r_state    <= ST_START;
                    end else begin
                        r_idx    <= r_idx + 1'b1;
                        mem_addr <= mem_addr + 16'd1;
                        // The final message word is always zero.
                        mem_write_data <= (r_idx == c_zero_word) ? 32'h0 : rotl1(mem_write_data);
                    end
                end

                ST_START: begin
                    res_cycles <= (r_idx == '0) ? 32'd1 : res_cycles + 32'd1;
                    if (r_idx == c_start_last) begin
                        core_start <= 1'b0;
                        r_wait     <= '0;
                        r_state    <= ST_WAIT;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end

                ST_WAIT: begin
                    if (res_cycles != 32'hFFFF_FFFF) begin
                        res_cycles <= res_cycles + 32'd1;
                    end
                    if (core_done) begin
                        mem_sel  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= core_output_addr;
                        r_idx    <= '0;
                        r_state  <= ST_READ;
                    end else if (r_wait == c_wait_last) begin
                        res_timeout <= 1'b1;
                        res_valid   <= 1'b1;
                        for (int k = 0; k < DIGEST_WORDS; k++) begin
                            r_digest[k] <= '0;
                        end
                        r_state <= ST_RESP;
                    end else begin
                        r_wait <= r_wait + 32'd1;
                    end
                end

                ST_READ: begin
                    // Memory read is registered, so data trails its address by one cycle.
                    if (r_idx != '0) begin
                        r_digest[3'(r_idx - 1'b1)] <= mem_read_data;
                    end
                    if (r_idx == c_read_last) begin
                        mem_sel   <= 1'b0;
                        res_valid <= 1'b1;
                        r_state   <= ST_RESP;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                        if (r_idx < c_addr_last) begin
                            mem_addr <= mem_addr + 16'd1;
                        end
                    end
                end

                ST_RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sha256_host.sv
// ============================================================================
// Module  : tb_sha256_host
// Brief   : Self-checking bench for sha256_host with core and dpsram models.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sha256_host;

    localparam int N   = 20;
    localparam int TMO = 50;

    typedef struct packed {
        logic [255:0] digest;
        logic [31:0]  cycles;
        logic         timeout;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [31:0]  cmd_seed;
    logic [15:0]  cmd_msg_addr;
    logic [15:0]  cmd_out_addr;
    logic         res_valid;
    logic         res_ready;
    logic [255:0] res_digest;
    logic [31:0]  res_cycles;
    logic         res_timeout;
    logic         core_start;
    logic [15:0]  core_message_addr;
    logic [15:0]  core_output_addr;
    logic         core_done;
    logic         mem_sel;
    logic         mem_clk;
    logic         mem_we;
    logic [15:0]  mem_addr;
    logic [31:0]  mem_write_data;
    logic [31:0]  mem_read_data;

    logic [31:0]  mem [0:65535];
    logic         model_done;
    logic         stray_done;
    logic         core_wr;
    logic [15:0]  core_wr_addr;
    logic [31:0]  core_wr_seed;
    logic         prev_start;
    int           core_r;
    bit           core_never;
    int           t_done;
    int           pcyc = 0;
    int           run_cnt = 0;
    int           last_run = 0;
    int           n_runs = 0;
    int           n_checks;
    int           n_fail;
    exp_t         exp_q [$];

    always #5 clk = ~clk;

    assign core_done = model_done | stray_done;

    sha256_host #(
        .NUM_OF_WORDS   (N),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_seed          (cmd_seed),
        .cmd_msg_addr      (cmd_msg_addr),
        .cmd_out_addr      (cmd_out_addr),
        .res_valid         (res_valid),
        .res_ready         (res_ready),
        .res_digest        (res_digest),
        .res_cycles        (res_cycles),
        .res_timeout       (res_timeout),
        .core_start        (core_start),
        .core_message_addr (core_message_addr),
        .core_output_addr  (core_output_addr),
        .core_done         (core_done),
        .mem_sel           (mem_sel),
        .mem_clk           (mem_clk),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_write_data    (mem_write_data),
        .mem_read_data     (mem_read_data)
    );

    function automatic logic [31:0] dig_word(input logic [31:0] s, input int k);
        return {s[15:0], s[31:16]} ^ (32'h9E37_79B9 * 32'(k + 1));
    endfunction

    function automatic logic [255:0] exp_digest(input logic [31:0] s);
        logic [255:0] d;
        d = '0;
        for (int k = 0; k < 8; k++) d[255-32*k -: 32] = dig_word(s, k);
        return d;
    endfunction

    function automatic logic [31:0] msg_word(input logic [31:0] s, input int i);
        logic [31:0] w;
        w = s;
        if (i == N - 1) return 32'h0;
        for (int k = 0; k < i; k++) w = {w[30:0], w[31]};
        return w;
    endfunction

    always @(posedge clk) pcyc <= pcyc + 1;

    // dpsram: host port gated by mem_sel, core writes its digest on done
    always @(posedge clk) begin
        if (mem_sel && mem_we) mem[mem_addr] <= mem_write_data;
        if (core_wr) begin
            for (int k = 0; k < 8; k++) mem[core_wr_addr + 16'(k)] <= dig_word(core_wr_seed, k);
        end
        mem_read_data <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (core_start) begin
            run_cnt <= run_cnt + 1;
        end else if (run_cnt != 0) begin
            last_run <= run_cnt;
            n_runs   <= n_runs + 1;
            run_cnt  <= 0;
        end
    end

    // Core model: done R cycles after start falls
    initial begin
        prev_start = 1'b0;
        model_done = 1'b0;
        core_wr = 1'b0;
        core_wr_addr = '0;
        core_wr_seed = '0;
        t_done = 0;
        forever begin
            @(negedge clk);
            if (prev_start && !core_start && !core_never) begin
                repeat (core_r) @(negedge clk);
                model_done   = 1'b1;
                core_wr      = 1'b1;
                core_wr_addr = core_output_addr;
                core_wr_seed = mem[core_message_addr];
                t_done       = pcyc;
                @(negedge clk);
                model_done = 1'b0;
                core_wr    = 1'b0;
                prev_start = 1'b0;
            end else begin
                prev_start = core_start;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic send_cmd(input logic [31:0] s, input logic [15:0] m, input logic [15:0] o,
                            output bit ok);
        @(negedge clk);
        cmd_seed = s;
        cmd_msg_addr = m;
        cmd_out_addr = o;
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_resp(output bit got, output int lat);
        got = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (res_valid) begin
                got = 1'b1;
                break;
            end
        end
        lat = pcyc - t_done;
    endtask

    task automatic ack_resp();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({cmd_ready, res_valid, res_digest, res_cycles, res_timeout, core_start, core_message_addr,
             core_output_addr, mem_sel, mem_we, mem_addr, mem_write_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b valid=%b start=%b sel=%b we=%b addr=%h want all zero",
                     cmd_ready, res_valid, core_start, mem_sel, mem_we, mem_addr);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (mem_clk !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mem_clk: got %b want 1", mem_clk);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_idle_ready: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_basic();
        exp_t e;
        exp_t g;
        bit ok;
        bit got;
        int lat;
        int runs0;
        core_r = 0;
        runs0 = n_runs;
        send_cmd(32'h0123_4567, 16'd0, 16'd1000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_accept: got no accept want accept"); end
        e.digest = exp_digest(32'h0123_4567); e.cycles = 32'd3; e.timeout = 1'b0;
        exp_q.push_back(e);
        wait_resp(got, lat);
        g = exp_q.pop_front();
        n_checks++; if (!got) begin n_fail++; $display("FAIL basic_resp: got no res_valid want res_valid"); end
        n_checks++; if (res_digest !== g.digest) begin n_fail++; $display("FAIL basic_digest: got %h want %h", res_digest, g.digest); end
        n_checks++; if (res_cycles !== g.cycles) begin n_fail++; $display("FAIL basic_cycles: got %0d want %0d", res_cycles, g.cycles); end
        n_checks++; if (res_timeout !== g.timeout) begin n_fail++; $display("FAIL basic_timeout: got %b want %b", res_timeout, g.timeout); end
        n_checks++; if (lat !== 10) begin n_fail++; $display("FAIL basic_done_to_valid: got %0d want 10", lat); end
        n_checks++; if (mem[0] !== 32'h0123_4567) begin n_fail++; $display("FAIL basic_w0: got %h want 01234567", mem[0]); end
        n_checks++; if (mem[1] !== 32'h0246_8ACE) begin n_fail++; $display("FAIL basic_w1: got %h want 02468ace", mem[1]); end
        n_checks++; if (mem[2] !== 32'h048D_159C) begin n_fail++; $display("FAIL basic_w2: got %h want 048d159c", mem[2]); end
        n_checks++; if (mem[3] !== 32'h091A_2B38) begin n_fail++; $display("FAIL basic_w3: got %h want 091a2b38", mem[3]); end
        n_checks++; if (mem[19] !== 32'h0) begin n_fail++; $display("FAIL basic_w19: got %h want 00000000", mem[19]); end
        for (int i = 4; i < N - 1; i++) begin
            n_checks++;
            if (mem[i] !== msg_word(32'h0123_4567, i)) begin
                n_fail++; $display("FAIL basic_word%0d: got %h want %h", i, mem[i], msg_word(32'h0123_4567, i));
            end
        end
        n_checks++; if (last_run !== 2 || n_runs - runs0 !== 1) begin n_fail++; $display("FAIL basic_start_len: got %0d cycles in %0d pulses want 2 in 1", last_run, n_runs - runs0); end
        n_checks++; if (core_output_addr !== 16'd1000) begin n_fail++; $display("FAIL basic_out_addr: got %h want %h", core_output_addr, 16'd1000); end
        ack_resp();
        n_checks++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin n_fail++; $display("FAIL basic_back_idle: got ready=%b valid=%b want 1 0", cmd_ready, res_valid); end
    endtask

    task automatic test_addr_wrap();
        exp_t e;
        exp_t g;
        bit ok;
        bit got;
        int lat;
        logic [31:0] s;
        s = 32'hDEAD_BEEF;
        core_r = 5;
        send_cmd(s, 16'hFFFE, 16'hFFFC, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_accept: got no accept want accept"); end
        e.digest = exp_digest(s); e.cycles = 32'd8; e.timeout = 1'b0;
        exp_q.push_back(e);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (core_start) break;
        end
        n_checks++; if (mem[16'hFFFE] !== s) begin n_fail++; $display("FAIL wrap_w0: got %h want %h", mem[16'hFFFE], s); end
        n_checks++; if (mem[16'hFFFF] !== msg_word(s, 1)) begin n_fail++; $display("FAIL wrap_w1: got %h want %h", mem[16'hFFFF], msg_word(s, 1)); end
        n_checks++; if (mem[16'h0000] !== msg_word(s, 2)) begin n_fail++; $display("FAIL wrap_w2: got %h want %h", mem[16'h0000], msg_word(s, 2)); end
        n_checks++; if (mem[16'h0011] !== 32'h0) begin n_fail++; $display("FAIL wrap_w19: got %h want 0", mem[16'h0011]); end
        wait_resp(got, lat);
        g = exp_q.pop_front();
        n_checks++; if (!got) begin n_fail++; $display("FAIL wrap_resp: got no res_valid want res_valid"); end
        n_checks++; if (res_digest !== g.digest) begin n_fail++; $display("FAIL wrap_digest: got %h want %h", res_digest, g.digest); end
        n_checks++; if (res_cycles !== g.cycles) begin n_fail++; $display("FAIL wrap_cycles: got %0d want %0d", res_cycles, g.cycles); end
        n_checks++; if (lat !== 10) begin n_fail++; $display("FAIL wrap_done_to_valid: got %0d want 10", lat); end
        ack_resp();
    endtask

    task automatic test_timeout();
        exp_t e;
        exp_t g;
        bit ok;
        bit got;
        int lat;
        core_never = 1'b1;
        send_cmd(32'h55AA_00FF, 16'h2000, 16'h3000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL timeout_accept: got no accept want accept"); end
        e.digest = '0; e.cycles = 32'd52; e.timeout = 1'b1;
        exp_q.push_back(e);
        wait_resp(got, lat);
        g = exp_q.pop_front();
        n_checks++; if (!got) begin n_fail++; $display("FAIL timeout_resp: got no res_valid want res_valid"); end
        n_checks++; if (res_timeout !== g.timeout) begin n_fail++; $display("FAIL timeout_flag: got %b want %b", res_timeout, g.timeout); end
        n_checks++; if (res_digest !== g.digest) begin n_fail++; $display("FAIL timeout_digest: got %h want %h", res_digest, g.digest); end
        n_checks++; if (res_cycles !== g.cycles) begin n_fail++; $display("FAIL timeout_cycles: got %0d want %0d", res_cycles, g.cycles); end
        ack_resp();
        core_never = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        exp_t g;
        bit ok;
        bit got;
        int lat;
        logic [255:0] snap_d;
        logic [31:0] snap_c;
        core_r = 2;
        send_cmd(32'h0BAD_F00D, 16'h0100, 16'h0200, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_accept: got no accept want accept"); end
        e.digest = exp_digest(32'h0BAD_F00D); e.cycles = 32'd5; e.timeout = 1'b0;
        exp_q.push_back(e);
        wait_resp(got, lat);
        n_checks++; if (!got) begin n_fail++; $display("FAIL bp_resp: got no res_valid want res_valid"); end
        snap_d = res_digest;
        snap_c = res_cycles;
        cmd_seed = 32'hC001_D00D;
        cmd_msg_addr = 16'h0400;
        cmd_out_addr = 16'h0500;
        cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (res_valid !== 1'b1 || res_digest !== snap_d || res_cycles !== snap_c || cmd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got valid=%b ready=%b cycles=%0d want valid=1 ready=0 cycles=%0d",
                         i, res_valid, cmd_ready, res_cycles, snap_c);
            end
        end
        g = exp_q.pop_front();
        n_checks++; if (res_digest !== g.digest || res_cycles !== g.cycles) begin n_fail++; $display("FAIL bp_first: got %h/%0d want %h/%0d", res_digest, res_cycles, g.digest, g.cycles); end
        ack_resp();
        n_checks++; if (cmd_ready !== 1'b1 || core_message_addr !== 16'h0100) begin n_fail++; $display("FAIL bp_no_early_accept: got ready=%b msg=%h want 1 0100", cmd_ready, core_message_addr); end
        e.digest = exp_digest(32'hC001_D00D); e.cycles = 32'd5; e.timeout = 1'b0;
        exp_q.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++; if (core_message_addr !== 16'h0400 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_second_accept: got msg=%h ready=%b want 0400 0", core_message_addr, cmd_ready); end
        wait_resp(got, lat);
        g = exp_q.pop_front();
        n_checks++; if (!got || res_digest !== g.digest || res_cycles !== g.cycles) begin n_fail++; $display("FAIL bp_second: got %h/%0d want %h/%0d", res_digest, res_cycles, g.digest, g.cycles); end
        ack_resp();
    endtask

    task automatic test_reset_mid_write();
        exp_t e;
        exp_t g;
        bit ok;
        bit got;
        int lat;
        send_cmd(32'h1357_9BDF, 16'h0600, 16'h0700, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_accept: got no accept want accept"); end
        for (int k = 0; k < 50; k++) begin
            if (mem_we && mem_addr == 16'h0607) break;
            @(negedge clk);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({cmd_ready, res_valid, res_digest, res_cycles, res_timeout, core_start, core_message_addr,
             core_output_addr, mem_sel, mem_we, mem_addr, mem_write_data} !== '0) begin
            n_fail++;
            $display("FAIL rst_async_outputs: got sel=%b we=%b addr=%h data=%h want all zero",
                     mem_sel, mem_we, mem_addr, mem_write_data);
        end
        n_checks++; if (mem[16'h0606] !== msg_word(32'h1357_9BDF, 6)) begin n_fail++; $display("FAIL rst_partial_kept: got %h want %h", mem[16'h0606], msg_word(32'h1357_9BDF, 6)); end
        @(negedge clk);
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we_low: got %b want 0", mem_we); end
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_idle: got ready=%b want 1", cmd_ready); end
        core_r = 1;
        send_cmd(32'h2468_ACE0, 16'h0800, 16'h0900, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_fresh_accept: got no accept want accept"); end
        e.digest = exp_digest(32'h2468_ACE0); e.cycles = 32'd4; e.timeout = 1'b0;
        exp_q.push_back(e);
        wait_resp(got, lat);
        g = exp_q.pop_front();
        n_checks++; if (!got || res_digest !== g.digest) begin n_fail++; $display("FAIL rst_fresh_digest: got %h want %h", res_digest, g.digest); end
        n_checks++; if (res_cycles !== g.cycles || res_timeout !== g.timeout) begin n_fail++; $display("FAIL rst_fresh_cycles: got %0d/%b want %0d/%b", res_cycles, res_timeout, g.cycles, g.timeout); end
        ack_resp();
    endtask

    task automatic test_stray_done();
        exp_t e;
        exp_t g;
        bit ok;
        bit got;
        int lat;
        core_r = 4;
        send_cmd(32'h89AB_CDEF, 16'h0A00, 16'h0B00, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL stray_accept: got no accept want accept"); end
        e.digest = exp_digest(32'h89AB_CDEF); e.cycles = 32'd7; e.timeout = 1'b0;
        exp_q.push_back(e);
        stray_done = 1'b1;
        repeat (3) @(negedge clk);
        stray_done = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (core_start) break;
        end
        stray_done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        stray_done = 1'b0;
        wait_resp(got, lat);
        g = exp_q.pop_front();
        n_checks++; if (!got || res_digest !== g.digest) begin n_fail++; $display("FAIL stray_digest: got %h want %h", res_digest, g.digest); end
        n_checks++; if (res_cycles !== g.cycles) begin n_fail++; $display("FAIL stray_cycles: got %0d want %0d", res_cycles, g.cycles); end
        n_checks++; if (lat !== 10) begin n_fail++; $display("FAIL stray_done_to_valid: got %0d want 10", lat); end
        ack_resp();
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        reset_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_seed = '0;
        cmd_msg_addr = '0;
        cmd_out_addr = '0;
        res_ready = 1'b0;
        stray_done = 1'b0;
        core_r = 0;
        core_never = 1'b0;
        test_reset();
        test_basic();
        test_addr_wrap();
        test_timeout();
        test_back_to_back();
        test_reset_mid_write();
        test_stray_done();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
